// File: rtl/lcd_avalon_driver.sv
// Avalon-MM byte slave that turns each write into a timed HD44780 8-bit bus cycle.
// Optional power-on init sequence (0x38, 0x0C, 0x01, 0x06) enabled by defining LCD_INIT_SEQ_EN.
module lcd_avalon_driver #(
  parameter int SETUP_CYCLES      = 2,
  parameter int PULSE_CYCLES      = 12,
  parameter int HOLD_CYCLES       = 2,
  parameter int CMD_WAIT_CYCLES   = 2000,
  parameter int CLEAR_WAIT_CYCLES = 82000,
  parameter int POWERUP_CYCLES    = 750000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       address,
  input  logic       chipselect,
  input  logic       byteenable,
  input  logic       read,
  input  logic       write,
  input  logic [7:0] writedata,
  output logic       waitrequest,
  output logic [7:0] readdata,
  output logic [1:0] response,
  output logic [7:0] LCD_DATA,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic       LCD_ON,
  output logic       LCD_BLON
);

  localparam int MAX_A   = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
  localparam int MAX_B   = (MAX_A > HOLD_CYCLES) ? MAX_A : HOLD_CYCLES;
  localparam int MAX_C   = (MAX_B > CMD_WAIT_CYCLES) ? MAX_B : CMD_WAIT_CYCLES;
  localparam int MAX_D   = (MAX_C > CLEAR_WAIT_CYCLES) ? MAX_C : CLEAR_WAIT_CYCLES;
  localparam int MAX_CYC = (MAX_D > POWERUP_CYCLES) ? MAX_D : POWERUP_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] L_SETUP = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] L_PULSE = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] L_HOLD  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] L_CMD   = CW'(CMD_WAIT_CYCLES - 1);
  localparam logic [CW-1:0] L_CLEAR = CW'(CLEAR_WAIT_CYCLES - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_PULSE = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
`ifdef LCD_INIT_SEQ_EN
  localparam logic [2:0] S_INIT  = 3'd6;
  localparam logic [2:0] RESET_STATE = S_INIT;
  localparam logic [CW-1:0] RESET_CNT = CW'(POWERUP_CYCLES - 1);
`else
  localparam logic [2:0] RESET_STATE = S_IDLE;
  localparam logic [CW-1:0] RESET_CNT = '0;
`endif

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic          req;
  logic          clear_cmd;
  logic          cnt_zero;
  logic          unused_byteenable;

  assign req         = chipselect & (write | read);
  assign waitrequest = req & (state != S_DONE);
  assign readdata    = 8'h00;
  assign LCD_RW      = 1'b0;
  assign LCD_ON      = 1'b1;
  assign LCD_BLON    = 1'b1;
  assign cnt_zero    = (cnt == '0);
  assign unused_byteenable = byteenable;

  // Clear (0x01) and return-home (0x02) need the long busy time; data bytes never do.
  assign clear_cmd = ~LCD_RS & ((LCD_DATA == 8'h01) | (LCD_DATA == 8'h02));

`ifdef LCD_INIT_SEQ_EN
  logic [1:0] init_idx;
  logic       init_busy;

  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    init_byte = 8'h38;
      2'd1:    init_byte = 8'h0C;
      2'd2:    init_byte = 8'h01;
      default: init_byte = 8'h06;
    endcase
  endfunction
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RESET_STATE;
      cnt      <= RESET_CNT;
      LCD_EN   <= 1'b0;
      LCD_RS   <= 1'b0;
      LCD_DATA <= 8'h00;
      response <= 2'b00;
`ifdef LCD_INIT_SEQ_EN
      init_idx  <= 2'd0;
      init_busy <= 1'b1;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (chipselect & write) begin
            LCD_RS   <= address;
            LCD_DATA <= writedata;
            response <= 2'b00;
            cnt      <= L_SETUP;
            state    <= S_SETUP;
          end else if (chipselect & read) begin
            response <= 2'b10;
            cnt      <= '0;
            state    <= S_DONE;
          end
        end
        S_SETUP: begin
          if (cnt_zero) begin
            LCD_EN <= 1'b1;
            cnt    <= L_PULSE;
            state  <= S_PULSE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_PULSE: begin
          if (cnt_zero) begin
            LCD_EN <= 1'b0;
            cnt    <= L_HOLD;
            state  <= S_HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_HOLD: begin
          if (cnt_zero) begin
            cnt   <= clear_cmd ? L_CLEAR : L_CMD;
            state <= S_WAIT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_WAIT: begin
          if (cnt_zero) begin
`ifdef LCD_INIT_SEQ_EN
            // Internal init commands chain straight into the next one with no Avalon handshake.
            if (init_busy) begin
              if (init_idx == 2'd3) begin
                init_busy <= 1'b0;
                cnt       <= '0;
                state     <= S_IDLE;
              end else begin
                init_idx <= init_idx + 2'd1;
                LCD_DATA <= init_byte(init_idx + 2'd1);
                cnt      <= L_SETUP;
                state    <= S_SETUP;
              end
            end else begin
              cnt   <= '0;
              state <= S_DONE;
            end
`else
            cnt   <= '0;
            state <= S_DONE;
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DONE: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
`ifdef LCD_INIT_SEQ_EN
        S_INIT: begin
          if (cnt_zero) begin
            LCD_RS   <= 1'b0;
            LCD_DATA <= init_byte(2'd0);
            cnt      <= L_SETUP;
            state    <= S_SETUP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`endif
        default: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
